dbus_demux_1x4: RTL
===================

DBUS_DEMUX_1X4 -- requirements
Module: dbus_demux_1x4

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of cycles a slave may take before the transaction is aborted.
REQ-002 SHALL have parameter REGION_EN, default 4'b1111, where bit n enables slave port n.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have upstream request ports:
- req_valid, input, 1
- req_ready, output, 1
- req_addr, input, 32
- req_wdata, input, 32
- req_we, input, 1
- req_mask, input, 4 (byte enables)
REQ-006 SHALL have upstream response ports:
- rsp_valid, output, 1 (one-cycle pulse, no backpressure)
- rsp_rdata, output, 32
- rsp_err, output, 1
REQ-007 SHALL have downstream request ports, indexed n = 0..3:
- slv_valid, output, 4
- slv_ready, input, 4
- slv_addr, output, 32 (shared)
- slv_wdata, output, 32 (shared)
- slv_we, output, 1 (shared)
- slv_mask, output, 4 (shared)
REQ-008 SHALL have downstream response ports:
- slv_rsp_valid, input, 4
- slv_rdata0..slv_rdata3, input, 32 each

Function
REQ-009 SHALL decode the target slave as sel = req_addr[31:30], captured at acceptance.
REQ-010 SHALL implement FSM states IDLE, REQ, RSP and ERR, with exactly one outstanding transaction.
REQ-011 SHALL assert req_ready = 1 only in IDLE; a transfer occurs when req_valid & req_ready.
REQ-012 On transfer, SHALL register addr, wdata, we, mask and sel.
- Next state is ERR if REGION_EN[sel] = 0, or if req_mask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Next state is ERR if the mask is misaligned: halfword mask with addr[0] = 1, or 1111 with addr[1:0] != 0.
- Otherwise next state is REQ.
REQ-013 In REQ, SHALL assert only slv_valid[sel] and drive the registered fields; all other slv_valid bits are 0.
REQ-014 In REQ, when slv_ready[sel] = 1, SHALL move to RSP; slv_valid[sel] deasserts in RSP.
REQ-015 In RSP, when slv_rsp_valid[sel] = 1, SHALL register rsp_valid = 1, rsp_err = 0 and rsp_rdata = slv_rdata[sel] (0 when we = 1), then return to IDLE.
- Minimum latency from upstream acceptance to rsp_valid is 3 cycles.
REQ-016 SHALL ignore slv_ready and slv_rsp_valid from non-selected slaves in all states.
REQ-017 SHALL ignore slv_rsp_valid[sel] while in REQ, i.e. before the handshake completes.
REQ-018 SHALL clear a timeout counter to 0 on acceptance and increment it each cycle in REQ and RSP, saturating at TIMEOUT.
- When the count equals TIMEOUT, SHALL enter ERR instead of the normal transition, even if the slave handshakes in that same cycle.
REQ-019 In ERR, for one cycle, SHALL register rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, drive slv_valid = 0, then return to IDLE.
REQ-020 SHALL drive rsp_valid for exactly one cycle per accepted request and hold it 0 otherwise.
- rsp_rdata and rsp_err are held from the last response.
REQ-021 SHALL accept a new request in the cycle immediately after the rsp_valid pulse, since IDLE is re-entered then.

Reset
REQ-022 While rst = 1, SHALL hold the FSM in IDLE and all of the following at 0: req_ready, rsp_valid, rsp_rdata, rsp_err, slv_valid, slv_addr, slv_wdata, slv_we, slv_mask, the timeout counter and the registered sel.
REQ-023 Reset asserted mid-transaction SHALL abort it with no response.
- slv_valid drops asynchronously.
- req_ready = 1 from the first clock edge after deassertion.

Structure
REQ-024 A shared package dbus_pkg SHALL hold:
- the FSM state enum
- the 2-bit slave-select typedef
- the legal-mask constants
REQ-025 Response data selection SHALL reuse the existing mux_4x1 module with select_line = registered sel; no other sub-module.

Verification
REQ-026 Read to 0x4000_0010, mask 1111; slave 1 sets ready in its first REQ cycle and responds 1 cycle later with 0xDEAD_BEEF -> exactly one rsp_valid, rdata 0xDEAD_BEEF, err 0, 3 cycles after acceptance.
REQ-027 Write to 0xC000_0002, mask 1100, wdata 0x1234_0000 -> slv_valid = 4'b1000, slave 3 sees wdata and mask; response rdata 0, err 0.
REQ-028 Read with mask 1111 at 0x0000_0001, and separately with REGION_EN = 4'b1110 to 0x0000_0000 -> no slv_valid; rsp_err = 1, rdata 0 two cycles after acceptance.
REQ-029 TIMEOUT = 4, slave 2 never responds after ready -> rsp_err = 1 when the count reaches 4; a late slv_rsp_valid[2] afterwards produces no response.
REQ-030 Slave 0 asserts spurious slv_rsp_valid[0] during a slave-2 transaction, and rst is pulsed in RSP of a later transaction -> spurious response ignored; after reset, outputs are all zero, req_ready = 1, and the next request completes normally.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and constants for the single-outstanding data-bus demultiplexer.
package dbus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRsp,
    StErr
  } dbus_state_e;

  typedef logic [1:0] dbus_sel_t;

  localparam logic [3:0] MaskByte0 = 4'b0001;
  localparam logic [3:0] MaskByte1 = 4'b0010;
  localparam logic [3:0] MaskByte2 = 4'b0100;
  localparam logic [3:0] MaskByte3 = 4'b1000;
  localparam logic [3:0] MaskHalf0 = 4'b0011;
  localparam logic [3:0] MaskHalf1 = 4'b1100;
  localparam logic [3:0] MaskWord  = 4'b1111;

  // True when the byte-enable pattern is legal and naturally aligned to the address.
  function automatic logic mask_ok(input logic [3:0] mask, input logic [1:0] addr_lo);
    logic ok;
    case (mask)
      MaskByte0, MaskByte1, MaskByte2, MaskByte3: ok = 1'b1;
      MaskHalf0, MaskHalf1:                       ok = ~addr_lo[0];
      MaskWord:                                   ok = (addr_lo == 2'b00);
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mux_4x1.sv
// Generic 4:1 multiplexer.
module mux_4x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       select_line,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    case (select_line)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/dbus_demux_1x4.sv
// One-to-four data-bus demultiplexer: address-decoded routing to four slaves with mask
// checking, a per-transaction timeout and exactly one outstanding request.
module dbus_demux_1x4
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [3:0]  REGION_EN = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  slv_valid,
  input  logic [3:0]  slv_ready,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic        slv_we,
  output logic [3:0]  slv_mask,
  input  logic [3:0]  slv_rsp_valid,
  input  logic [31:0] slv_rdata0,
  input  logic [31:0] slv_rdata1,
  input  logic [31:0] slv_rdata2,
  input  logic [31:0] slv_rdata3
);

  localparam int unsigned    CntW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  dbus_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, wdata_q;
  logic            we_q;
  logic [3:0]      mask_q;
  dbus_sel_t       sel_q;
  dbus_sel_t       sel_req;
  logic            ready_en_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [31:0]     mux_rdata;
  logic            accept;
  logic            timed_out;

  assign sel_req   = req_addr[31:30];
  // Held low until the first edge after reset so nothing is accepted while rst is high.
  assign req_ready = (state_q == StIdle) & ready_en_q;
  assign accept    = req_valid & req_ready;
  assign timed_out = (cnt_q == CntMax);

  mux_4x1 #(
    .WIDTH(32)
  ) u_rdata_mux (
    .in0        (slv_rdata0),
    .in1        (slv_rdata1),
    .in2        (slv_rdata2),
    .in3        (slv_rdata3),
    .select_line(sel_q),
    .out        (mux_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          if (!REGION_EN[sel_req] || !mask_ok(req_mask, req_addr[1:0])) begin
            state_d = StErr;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (!timed_out) cnt_d = cnt_q + CntW'(1);
        // Timeout wins over a handshake arriving in the same cycle.
        if (timed_out) begin
          state_d = StErr;
        end else if (slv_ready[sel_q]) begin
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (!timed_out) cnt_d = cnt_q + CntW'(1);
        if (timed_out) begin
          state_d = StErr;
        end else if (slv_rsp_valid[sel_q]) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'd0 : mux_rdata;
        end
      end
      StErr: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_en_q  <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      mask_q  <= 4'd0;
      sel_q   <= 2'd0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
      mask_q  <= req_mask;
      sel_q   <= sel_req;
    end
  end

  assign slv_valid = (state_q == StReq) ? (4'b0001 << sel_q) : 4'b0000;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_we    = we_q;
  assign slv_mask  = mask_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
